// File: rtl/sr_ff_driver.sv
// Serializes a WIDTH-bit word LSB-first into S/R excitation commands for one SR flip-flop,
// reads q/qbar back after every bit and records mismatches.
module sr_ff_driver #(
    parameter int WIDTH       = 8,
    parameter bit FORCE_DRIVE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    input  logic             qbar_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       mismatch_cnt
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t           state;
    logic [WIDTH-1:0] word;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             exp_q;
    logic             exp_now;
    logic             mismatch;
    logic             bit_next;

    // {s,r} for target bit d given the believed flip-flop state; never returns 2'b11.
    function automatic logic [1:0] excite(input logic d, input logic cur);
        if (d == cur && !FORCE_DRIVE) return 2'b00;
        return d ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign mismatch = (q_fb != exp_q) || (qbar_fb != ~q_fb);
    // After a failed check the real flip-flop state is what the next excitation must follow.
    assign exp_now  = (state == CHECK && mismatch) ? q_fb : exp_q;
    assign idx_next = idx + 1'b1;
    assign bit_next = word[idx_next];
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // s/r are registered, so each bit's command is computed on the edge that enters DRIVE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            exp_q        <= 1'b0;
            s            <= 1'b0;
            r            <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            mismatch_cnt <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word   <= in_data;
                        idx    <= '0;
                        {s, r} <= excite(in_data[0], exp_q);
                        exp_q  <= in_data[0];
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    s     <= 1'b0;
                    r     <= 1'b0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        err          <= 1'b1;
                        mismatch_cnt <= sat_inc(mismatch_cnt);
                    end
                    if (idx == LAST_IDX) begin
                        exp_q <= exp_now;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx    <= idx_next;
                        {s, r} <= excite(bit_next, exp_now);
                        exp_q  <= bit_next;
                        state  <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_ff_driver.sv
// Bench for sr_ff_driver: two instances (hold-optimised and forced drive) each looped back
// through a behavioural SR flip-flop with injectable readback faults.
module tb_sr_ff_driver;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       stuck = 1'b0;
    logic       qbar_flt = 1'b0;

    logic in_ready0, s0, r0, busy0, done0, err0, q_fb0, qbar_fb0, ffq0;
    logic in_ready1, s1, r1, busy1, done1, err1, q_fb1, qbar_fb1, ffq1;
    logic [7:0] cnt0, cnt1;

    int vectors = 0;
    int miscompares = 0;

    // Higher-level model state, one entry per instance (index 1 = forced drive).
    logic m_prev[2];
    logic m_ff[2];
    logic m_err[2];
    int   m_cnt[2];

    typedef struct {
        logic        rst_first;
        logic [7:0]  word;
        int          fault;
        int          fbit;
        logic [15:0] c0;
        logic [15:0] c1;
        logic        err;
        logic [7:0]  cnt;
    } vec_t;
    vec_t tbl[4];

    always #5 clock = ~clock;

    sr_ff_driver #(.WIDTH(8), .FORCE_DRIVE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .s(s0), .r(r0), .q_fb(q_fb0), .qbar_fb(qbar_fb0),
        .busy(busy0), .done(done0), .err(err0), .mismatch_cnt(cnt0));

    sr_ff_driver #(.WIDTH(8), .FORCE_DRIVE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .s(s1), .r(r1), .q_fb(q_fb1), .qbar_fb(qbar_fb1),
        .busy(busy1), .done(done1), .err(err1), .mismatch_cnt(cnt1));

    always_ff @(posedge clock) begin
        if (reset) ffq0 <= 1'b0;
        else if (s0 && !r0) ffq0 <= 1'b1;
        else if (r0 && !s0) ffq0 <= 1'b0;
    end
    always_ff @(posedge clock) begin
        if (reset) ffq1 <= 1'b0;
        else if (s1 && !r1) ffq1 <= 1'b1;
        else if (r1 && !s1) ffq1 <= 1'b0;
    end

    assign q_fb0    = stuck ? 1'b0 : ffq0;
    assign qbar_fb0 = qbar_flt ? q_fb0 : ~q_fb0;
    assign q_fb1    = stuck ? 1'b0 : ffq1;
    assign qbar_fb1 = qbar_flt ? q_fb1 : ~q_fb1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        chk("never_s_and_r", 16'((s0 & r0) | (s1 & r1)), 16'd0);
    end

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_prev[k] = 1'b0;
            m_ff[k]   = 1'b0;
            m_err[k]  = 1'b0;
            m_cnt[k]  = 0;
        end
    endtask

    // Word-level model: command per bit from the target bit and the last observed state,
    // then the flip-flop response and the readback check.
    task automatic model_word(input int k, input logic [7:0] w, input int fault, input int fbit,
                              output logic [15:0] cmds);
        logic d, q, qb;
        logic [1:0] c;
        cmds = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            d = w[i];
            if (k == 0 && d == m_prev[k]) c = 2'b00;
            else c = d ? 2'b10 : 2'b01;
            cmds[2*i +: 2] = c;
            if (c == 2'b10) m_ff[k] = 1'b1;
            else if (c == 2'b01) m_ff[k] = 1'b0;
            q  = (fault == 1) ? 1'b0 : m_ff[k];
            qb = (fault == 2 && fbit == i) ? q : ~q;
            if (q != d || qb != ~q) begin
                m_err[k] = 1'b1;
                m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
            end
            m_prev[k] = q;
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done, input logic e, input logic [7:0] n);
        chk({tag, "_in_ready"}, 16'({in_ready0, in_ready1}), 16'd3);
        chk({tag, "_busy"}, 16'({busy0, busy1}), 16'd0);
        chk({tag, "_sr"}, 16'({s0, r0, s1, r1}), 16'd0);
        chk({tag, "_done"}, 16'({done0, done1}), exp_done ? 16'd3 : 16'd0);
        chk({tag, "_err"}, 16'({err0, err1}), e ? 16'd3 : 16'd0);
        chk({tag, "_cnt0"}, 16'(cnt0), 16'(n));
        chk({tag, "_cnt1"}, 16'(cnt1), 16'(n));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        stuck = 1'b0;
        qbar_flt = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        chk_idle("reset", 1'b0, 1'b0, 8'd0);
    endtask

    // Entered at a negedge with both instances idle; returns at the negedge of the done cycle.
    task automatic run_word(input logic [7:0] w, input int fault, input int fbit,
                            input logic [15:0] c0, input logic [15:0] c1,
                            input logic e0, input logic e1, input logic [7:0] n0, input logic [7:0] n1);
        stuck = (fault == 1);
        chk("accept_ready", 16'({in_ready0, in_ready1}), 16'd3);
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            in_valid = 1'b0;
            chk("drive_sr0", 16'({s0, r0}), 16'(c0[2*i +: 2]));
            chk("drive_sr1", 16'({s1, r1}), 16'(c1[2*i +: 2]));
            chk("drive_status", 16'({busy0, busy1, in_ready0, in_ready1, done0, done1}), 16'b110000);
            @(negedge clock);
            qbar_flt = (fault == 2 && fbit == i);
            chk("check_status", 16'({s0, r0, s1, r1, busy0, busy1, done0, done1}), 16'b00001100);
        end
        @(negedge clock);
        qbar_flt = 1'b0;
        chk("done_pulse", 16'({done0, done1}), 16'd3);
        chk("done_ready", 16'({in_ready0, in_ready1, busy0, busy1}), 16'b1100);
        chk("done_err0", 16'(err0), 16'(e0));
        chk("done_err1", 16'(err1), 16'(e1));
        chk("done_cnt0", 16'(cnt0), 16'(n0));
        chk("done_cnt1", 16'(cnt1), 16'(n1));
    endtask

    task automatic run_model(input logic [7:0] w, input int fault, input int fbit);
        logic [15:0] c0, c1;
        model_word(0, w, fault, fbit, c0);
        model_word(1, w, fault, fbit, c1);
        run_word(w, fault, fbit, c0, c1, m_err[0], m_err[1], 8'(m_cnt[0]), 8'(m_cnt[1]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 8'h00, 0, 0, 16'h0000, 16'h5555, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 8'hA5, 0, 0, 16'h9866, 16'h9966, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 8'h0F, 2, 2, 16'h0100, 16'h55AA, 1'b1, 8'd1};
        tbl[3] = '{1'b1, 8'hFF, 1, 0, 16'hAAAA, 16'hAAAA, 1'b1, 8'd8};

        // Reset state held over ten idle cycles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk_idle("idle_hold", 1'b0, 1'b0, 8'd0);
        end

        // Table vectors; rows without a reset start in the previous word's done cycle.
        for (int t = 0; t < 4; t++) begin
            if (tbl[t].rst_first) do_reset();
            run_word(tbl[t].word, tbl[t].fault, tbl[t].fbit, tbl[t].c0, tbl[t].c1,
                     tbl[t].err, tbl[t].err, tbl[t].cnt, tbl[t].cnt);
        end
        @(negedge clock);
        chk("done_one_cycle", 16'({done0, done1}), 16'd0);

        // Mismatch counter saturation: 32 words with q stuck low.
        do_reset();
        for (int n = 0; n < 32; n++) run_model(8'hFF, 1, 0);
        chk("saturated_cnt", 16'(cnt0), 16'd255);

        // Reset in the DRIVE cycle of bit 3 discards the word.
        do_reset();
        stuck = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hA5;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
        chk("bit3_drive_busy", 16'({busy0, busy1}), 16'd3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        chk_idle("midop_reset", 1'b0, 1'b0, 8'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk_idle("after_reset", 1'b0, 1'b0, 8'd0);
        end

        // Reset and in_valid together: the word is not taken.
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h3C;
        @(negedge clock);
        reset = 1'b0;
        in_valid = 1'b0;
        chk_idle("reset_wins", 1'b0, 1'b0, 8'd0);
        run_model(8'h01, 0, 0);

        // Randomised words, faults and idle gaps against the model.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [7:0] w;
            int f, fault, fbit, gap;
            w = 8'($urandom);
            f = int'($urandom_range(0, 9));
            fault = (f < 6) ? 0 : (f < 8) ? 2 : 1;
            fbit = int'($urandom_range(0, 7));
            run_model(w, fault, fbit);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                chk("gap_idle", 16'({done0, done1, busy0, busy1, in_ready0, in_ready1}), 16'b000011);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sr_ff_driver.md
# sr_ff_driver

Initiator side of the SR flip-flop interface. It accepts a WIDTH-bit word over a valid/ready handshake and serializes it LSB-first into S/R excitation commands for one downstream SR flip-flop. The flip-flop's q/qbar are read back after each bit and checked against the expected state. The block sits between a register-level producer and a discrete SR flip-flop, which shares the same clock and reset. It serves as both a stimulus generator and a loopback checker.

## Interface
- WIDTH, 8, bits per word; must be ≥1.
- FORCE_DRIVE, 0, 0: emit hold (s=r=0) when the target bit equals the current state; 1: always emit set/reset.
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- in_valid  in  1  producer has a word.
- in_data  in  WIDTH  word to drive; bit 0 is sent first.
- in_ready  out  1  block can accept a word (high only in IDLE).
- s  out  1  set command to the flip-flop (registered).
- r  out  1  reset command to the flip-flop (registered).
- q_fb  in  1  flip-flop q readback.
- qbar_fb  in  1  flip-flop qbar readback.
- busy  out  1  a transaction is in progress.
- done  out  1  one-cycle pulse when a word completes.
- err  out  1  sticky mismatch flag.
- mismatch_cnt  out  8  saturating count of failed bit checks.

## Operation
- Reset values: state=IDLE; in_ready=1; s=0; r=0; busy=0; done=0; err=0; mismatch_cnt=0; shadow exp_q=0, matching the flip-flop's reset state q=0.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE:
  - On in_valid&&in_ready, latch in_data, set bit index to 0, and go to DRIVE.
  - Otherwise stay in IDLE.
- DRIVE (1 cycle):
  - Let d = word[idx].
  - If d==exp_q and FORCE_DRIVE=0, drive s/r=00.
  - Else if d=1, drive s/r=10.
  - Else drive s/r=01.
  - Set exp_q<=d. Go to CHECK.
- CHECK (1 cycle):
  - Drive s/r=00.
  - At the closing edge, compare: a mismatch occurs if q_fb!=exp_q or qbar_fb!=~q_fb.
  - On mismatch: set err<=1, increment mismatch_cnt (saturating at 255), and set exp_q<=q_fb so that later excitation tracks the real flip-flop state.
  - If idx==WIDTH-1, go to IDLE and assert done<=1. Otherwise increment idx and go to DRIVE.
- s=r=1 is never emitted, in any state or across reset.
- err and mismatch_cnt clear only on reset.
- busy = (state!=IDLE).

## Timing
- Each bit takes 2 cycles. The flip-flop captures s/r at the edge that ends DRIVE. q_fb is stable throughout CHECK and is sampled at the edge that ends CHECK.
- For a word accepted at edge E0:
  - Bit i: s/r are valid in the cycle after edge E0+2i.
  - Bit i is checked at edge E0+2i+2.
  - done is high for exactly the one cycle after edge E0+2·WIDTH.
  - in_ready is low for 2·WIDTH cycles.
- Back-to-back operation: a new word may be accepted in the same cycle that done is high. There is no bubble beyond the IDLE cycle.
- Reset mid-operation:
  - At the reset edge, the transaction is discarded and all outputs take their reset values.
  - s=r=0 in the following cycle; no done pulse is produced.
- Simultaneous reset and in_valid: reset wins and the word is not accepted.
- Mismatch on the last bit: err, mismatch_cnt and done all update at the same edge.

## Test plan
- Reset check: after reset, in_ready=1 and s=r=busy=done=err=0, mismatch_cnt=0. Hold in_valid=0 for 10 cycles; the outputs must not change.
- Loopback 8'hA5 to a real SR flip-flop, FORCE_DRIVE=0:
  - DRIVE-cycle s/r sequence must be 10,01,10,01,00,10,01,10.
  - done must pulse 16 cycles after the accept edge.
  - err=0.
- Loopback 8'h00 after reset: all s/r=00. Repeat with FORCE_DRIVE=1: all s/r=01. Both runs: err=0.
- q_fb stuck at 0 with qbar_fb=1, word 8'hFF: every DRIVE emits 10, err=1, mismatch_cnt=8. Repeat 32 words: mismatch_cnt saturates at 255.
- qbar_fb forced equal to q_fb during bit 2 of 8'h0F: err=1, mismatch_cnt=1, done still pulses on schedule.
- Reset asserted in the DRIVE cycle of bit 3: next cycle s=r=0, in_ready=1, no done. A following word 8'h01 completes normally.
